// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Control FSM for a multi-cycle MIPS datapath. It decodes the
//               opcode, issues per-state control strobes and stalls on a
//               shared variable-latency instruction/data memory using a
//               mem_ready handshake. A memory state that stays not-ready for
//               too long enters FAULT, and so does an illegal opcode. Also
//               counts retired instructions.
// Ports       : clk, reset (sync, active-high)
//               opcode[5:0]        instruction[31:26] from the IR
//               mem_ready          memory completes the access this cycle
//               pc_write, pc_write_cond, ir_write, iord, mem_read,
//               mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
//               alu_src_b[1:0], alu_op[1:0], pc_source[1:0]  datapath strobes
//               state[3:0]         current state (debug)
//               fault              sticky illegal-opcode / timeout flag
//               instr_count        retired-instruction counter (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int MAX_WAIT  = 15,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic                 ir_write,
    output logic                 iord,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 mem_to_reg,
    output logic                 reg_dst,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           pc_source,
    output logic [3:0]           state,
    output logic                 fault,
    output logic [CNT_WIDTH-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_FAULT     = 4'd15
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [8:0] c_MAX_WAIT = 9'(MAX_WAIT);

    state_t                 r_state;
    state_t                 w_next;
    logic [7:0]             r_wait;
    logic [7:0]             w_wait_next;
    logic [CNT_WIDTH-1:0]   r_count;
    logic                   w_in_mem;
    logic                   w_timeout;
    logic                   w_retire;

    // Memory states are the only ones where mem_ready matters.
    assign w_in_mem  = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                       (r_state == S_MEM_WR);
    // This not-ready cycle would be the MAX_WAIT-th in a row.
    assign w_timeout = w_in_mem && !mem_ready &&
                       (({1'b0, r_wait} + 9'd1) == c_MAX_WAIT);

    // Counter only runs while sitting in a memory state without ready; any
    // transition (including entry into a memory state) starts it from zero.
    assign w_wait_next = (w_in_mem && !mem_ready && (w_next == r_state)) ?
                         r_wait + 8'd1 : 8'd0;

    assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH) &&
                      (r_state != S_FAULT);

    always_comb begin
        w_next        = r_state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;

        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    c_OP_RTYPE:       w_next = S_R_EXEC;
                    c_OP_LW, c_OP_SW: w_next = S_MEM_ADDR;
                    c_OP_BEQ:         w_next = S_BRANCH;
                    c_OP_ADDI:        w_next = S_ADDI_EXEC;
                    c_OP_J:           w_next = S_JUMP;
                    default:          w_next = S_FAULT;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // Opcode is held in the IR, so sampling it again is safe.
                w_next    = (opcode == c_OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready)      w_next = S_MEM_WB;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready)      w_next = S_FETCH;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                w_next    = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                w_next        = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                w_next    = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                w_next    = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                w_next    = S_FETCH;
            end
            default: begin
                w_next = S_FAULT;
            end
        endcase

        // Reset wins immediately: no strobe may reach the datapath in the
        // cycle that reset is held.
        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            pc_source     = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_wait  <= 8'd0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_next;
            if (w_retire) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end
        end
    end

    // FAULT is absorbing until reset, so the state itself is the sticky flag.
    assign fault       = (r_state == S_FAULT);
    assign state       = r_state;
    assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control. Each instruction
//               is expanded by a reference model into the expected list of
//               states with the mem_ready value driven in each cycle; the
//               bench then drives that list and compares state, strobes,
//               fault and instr_count every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    localparam int TB_MAX_WAIT = 4;
    localparam int TB_CNT      = 8;

    localparam int ST_FETCH = 0,  ST_DECODE = 1, ST_MEM_ADDR = 2, ST_MEM_RD = 3;
    localparam int ST_MEM_WB = 4, ST_MEM_WR = 5, ST_R_EXEC = 6,  ST_R_WB = 7;
    localparam int ST_BRANCH = 8, ST_JUMP = 9,   ST_ADDI_EXEC = 10;
    localparam int ST_ADDI_WB = 11, ST_FAULT = 15;

    logic                clk = 1'b0;
    logic                reset;
    logic [5:0]          opcode;
    logic                mem_ready;
    logic                pc_write, pc_write_cond, ir_write, iord, mem_read;
    logic                mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]          alu_src_b, alu_op, pc_source;
    logic [3:0]          state;
    logic                fault;
    logic [TB_CNT-1:0]   instr_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [TB_CNT-1:0]   exp_cnt;
    int                  q_st[$];
    bit                  q_rd[$];

    multicycle_control #(
        .MAX_WAIT  (TB_MAX_WAIT),
        .CNT_WIDTH (TB_CNT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .state         (state),
        .fault         (fault),
        .instr_count   (instr_count)
    );

    always #5 clk = ~clk;

    wire [15:0] w_ctrl = {pc_write, pc_write_cond, ir_write, iord, mem_read,
                          mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                          alu_src_b, alu_op, pc_source};

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Strobe table taken directly from the per-state description.
    function automatic logic [15:0] exp_ctrl(input int s, input bit rdy);
        logic pw, pwc, irw, io, mr, mw, m2r, rd, rw, sa;
        logic [1:0] sb, op, ps;
        {pw, pwc, irw, io, mr, mw, m2r, rd, rw, sa} = '0;
        sb = 2'b00; op = 2'b00; ps = 2'b00;
        case (s)
            ST_FETCH:     begin mr = 1; sb = 2'b01; pw = rdy; irw = rdy; end
            ST_DECODE:    sb = 2'b11;
            ST_MEM_ADDR:  begin sa = 1; sb = 2'b10; end
            ST_MEM_RD:    begin mr = 1; io = 1; end
            ST_MEM_WB:    begin rw = 1; m2r = 1; end
            ST_MEM_WR:    begin mw = 1; io = 1; end
            ST_R_EXEC:    begin sa = 1; op = 2'b10; end
            ST_R_WB:      begin rw = 1; rd = 1; end
            ST_BRANCH:    begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
            ST_JUMP:      begin pw = 1; ps = 2'b10; end
            ST_ADDI_EXEC: begin sa = 1; sb = 2'b10; end
            ST_ADDI_WB:   rw = 1;
            default:      ;
        endcase
        return {pw, pwc, irw, io, mr, mw, m2r, rd, rw, sa, sb, op, ps};
    endfunction

    function automatic void push(input int s, input bit rdy);
        q_st.push_back(s);
        q_rd.push_back(rdy);
    endfunction

    // A memory phase: 'stalls' not-ready cycles then a ready one, unless the
    // stall run reaches MAX_WAIT, which ends in FAULT. Returns 1 on fault.
    function automatic bit push_mem(input int s, input int stalls);
        if (stalls >= TB_MAX_WAIT) begin
            for (int i = 0; i < TB_MAX_WAIT; i++) push(s, 1'b0);
            push(ST_FAULT, 1'($urandom));
            return 1'b1;
        end
        for (int i = 0; i < stalls; i++) push(s, 1'b0);
        push(s, 1'b1);
        return 1'b0;
    endfunction

    // rst_idx: -1 no reset, -2 random chance of reset, >=0 reset at that cycle.
    task automatic run_instr(input logic [5:0] op, input int sf, input int sm,
                             input int rst_idx);
        bit dead;
        bit aborted;
        int ri;
        q_st.delete();
        q_rd.delete();
        dead    = push_mem(ST_FETCH, sf);
        aborted = 1'b0;
        if (!dead) begin
            push(ST_DECODE, 1'($urandom));
            case (op)
                6'b000000: begin push(ST_R_EXEC, 1'($urandom)); push(ST_R_WB, 1'($urandom)); end
                6'b100011: begin
                    push(ST_MEM_ADDR, 1'($urandom));
                    dead = push_mem(ST_MEM_RD, sm);
                    if (!dead) push(ST_MEM_WB, 1'($urandom));
                end
                6'b101011: begin
                    push(ST_MEM_ADDR, 1'($urandom));
                    dead = push_mem(ST_MEM_WR, sm);
                end
                6'b000100: push(ST_BRANCH, 1'($urandom));
                6'b001000: begin push(ST_ADDI_EXEC, 1'($urandom)); push(ST_ADDI_WB, 1'($urandom)); end
                6'b000010: push(ST_JUMP, 1'($urandom));
                default:   begin push(ST_FAULT, 1'($urandom)); dead = 1'b1; end
            endcase
        end
        // FAULT must hold regardless of inputs.
        if (dead) for (int i = 0; i < 20; i++) push(ST_FAULT, 1'($urandom));

        ri = rst_idx;
        if (rst_idx == -2) ri = ($urandom_range(0, 7) == 0) ?
                                 int'($urandom_range(0, q_st.size() - 1)) : -1;

        opcode = op;
        for (int i = 0; i < q_st.size(); i++) begin
            @(negedge clk);
            mem_ready = q_rd[i];
            reset     = (i == ri);
            #1;
            check_eq("state", 32'(state), 32'(q_st[i]));
            check_eq("ctrl", 32'(w_ctrl), reset ? 32'd0 : 32'(exp_ctrl(q_st[i], q_rd[i])));
            check_eq("fault", 32'(fault), 32'(q_st[i] == ST_FAULT));
            check_eq("count", 32'(instr_count), 32'(exp_cnt));
            if (reset) begin
                aborted = 1'b1;
                break;
            end
        end

        if (aborted) begin
            exp_cnt = '0;
        end else if (dead) begin
            @(negedge clk);
            reset     = 1'b1;
            mem_ready = 1'($urandom);
            #1;
            check_eq("fault_rst_ctrl", 32'(w_ctrl), 32'd0);
            check_eq("fault_rst_cnt", 32'(instr_count), 32'(exp_cnt));
            exp_cnt = '0;
        end else begin
            exp_cnt = exp_cnt + 1'b1;
        end
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] ops [6];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
        return ops[$urandom_range(0, 5)];
    endfunction

    initial begin
        reset     = 1'b1;
        opcode    = 6'd0;
        mem_ready = 1'b0;
        exp_cnt   = '0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_ctrl", 32'(w_ctrl), 32'd0);
        check_eq("rst_fault", 32'(fault), 32'd0);
        check_eq("rst_count", 32'(instr_count), 32'd0);

        // Directed scenarios.
        run_instr(6'b000000, 0, 0, -1);   // R-type, 4 cycles
        run_instr(6'b100011, 0, 3, -1);   // lw with 3 stalls in MEM_RD
        run_instr(6'b111111, 0, 0, -1);   // illegal opcode
        run_instr(6'b000000, TB_MAX_WAIT, 0, -1);   // fetch timeout
        run_instr(6'b100011, 1, TB_MAX_WAIT, -1);   // MEM_RD timeout
        run_instr(6'b000010, 0, 0, -1);   // j
        run_instr(6'b000100, 0, 0, -1);   // beq
        run_instr(6'b101011, 0, 0, -1);   // sw
        run_instr(6'b001000, 0, 0, -1);   // addi
        run_instr(6'b101011, 0, 3, 3);    // reset in MEM_WR while not ready

        // Long legal run so the counter wraps through zero.
        for (int n = 0; n < 270; n++)
            run_instr(rand_op(), $urandom_range(0, 2), $urandom_range(0, 2), -1);

        // Unconstrained mix: random opcodes, timeouts and resets.
        for (int n = 0; n < 150; n++)
            run_instr(($urandom_range(0, 9) == 0) ? 6'($urandom) : rand_op(),
                      $urandom_range(0, TB_MAX_WAIT), $urandom_range(0, TB_MAX_WAIT), -2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
